// File: rtl/sr_arb_pkg.sv
// sr_arb_pkg: shared state encodings, command values and sizing helpers
package sr_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;
    localparam logic CMD_SET = 1'b1;
    localparam logic CMD_CLR = 1'b0;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: grants the first valid request after ptr (with wrap) and proposes the updated pointer
module rr_arbiter
    import sr_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req_i,
    input  logic [idx_w(N)-1:0]   ptr_i,
    input  logic                  en_i,
    output logic [N-1:0]          gnt_o,
    output logic [idx_w(N)-1:0]   idx_o,
    output logic                  any_o,
    output logic [idx_w(N)-1:0]   ptr_d_o
);
    localparam int IW = idx_w(N);
    logic [IW-1:0] k;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = '0;
        for (int i = 1; i <= N; i++) begin
            k = IW'((int'(ptr_i) + i) % N);
            if (en_i && req_i[k] && !any_o) begin
                gnt_o[k] = 1'b1;
                idx_o    = k;
                any_o    = 1'b1;
            end
        end
        ptr_d_o = any_o ? idx_o : ptr_i;
    end
endmodule

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin set/clear pulses for one shared sr_ff; SR_ARB_SKIP_REDUNDANT_EN grants no-op commands without driving
module sr_flag_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [NUM_REQ-1:0] req_set_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic               s_o,
    output logic               r_o,
    input  logic               q_i,
    output logic               busy_o,
    output logic               err_o
);
    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = $clog2(max_int(PULSE_CYC, GAP_CYC) + 1);
    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      ptr_q, ptr_d, arb_idx, arb_ptr;
    logic [NUM_REQ-1:0] arb_gnt, ready_q, ready_d;
    logic               cmd_q, cmd_d, s_q, s_d, r_q, r_d, busy_q, busy_d, err_q, err_d;
    logic               arb_any, skip;
    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .en_i    (state_q == IDLE),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .any_o   (arb_any),
        .ptr_d_o (arb_ptr)
    );
`ifdef SR_ARB_SKIP_REDUNDANT_EN
    assign skip = req_set_i[arb_idx] == q_i;
`else
    assign skip = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        ptr_d   = ptr_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        ready_d = '0;
        err_d   = err_q;
        case (state_q)
            IDLE: if (arb_any) begin
                ptr_d   = arb_ptr;
                ready_d = arb_gnt;
                if (!skip) begin
                    state_d = DRIVE;
                    cnt_d   = CW'(PULSE_CYC - 1);
                    cmd_d   = req_set_i[arb_idx];
                    s_d     = req_set_i[arb_idx] == CMD_SET;
                    r_d     = req_set_i[arb_idx] == CMD_CLR;
                end
            end
            DRIVE: if (cnt_q == '0) begin
                state_d = GAP;
                cnt_d   = CW'(GAP_CYC - 1);
            end else begin
                cnt_d = cnt_q - CW'(1);
                s_d   = s_q;
                r_d   = r_q;
            end
            GAP: if (cnt_q == '0) begin
                state_d = IDLE;
                err_d   = err_q | (q_i != cmd_q);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            cmd_q   <= CMD_CLR;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            ready_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            cmd_q   <= cmd_d;
            s_q     <= s_d;
            r_q     <= r_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end
    assign req_ready_o = ready_q;
    assign s_o         = s_q;
    assign r_o         = r_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
endmodule
